// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: picks the next PC from
// sequential/branch sources and runs the imem request / instr_valid handshake.
module pc_fetch_unit #(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_branch_en,
    input  logic             i_cond_true,
    input  logic [WIDTH-1:0] i_branch_target,
    input  logic             i_stall,
    input  logic             i_halt,
    input  logic             i_imem_ready,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus4,
    output logic             o_instr_valid,
    output logic             o_halted
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_imem_req;
    logic             r_instr_valid;
    logic             r_halted;

    logic [WIDTH-1:0] w_pc_plus_step;
    logic [WIDTH-1:0] w_branch_pc;

    assign w_pc_plus_step = r_pc + WIDTH'(PC_STEP);
    // Misaligned targets are silently word-aligned.
    assign w_branch_pc    = {i_branch_target[WIDTH-1:2], 2'b00};

    // Outputs are registered alongside the state so they decode the state being entered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_state    <= StFetch;
                    r_imem_req <= 1'b1;
                end
                StFetch: begin
                    if (i_imem_ready) begin
                        r_state       <= StExec;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                StExec: begin
                    if (i_stall) begin
                        r_state <= StExec;
                    end else if (i_halt) begin
                        r_state       <= StHalt;
                        r_instr_valid <= 1'b0;
                        r_halted      <= 1'b1;
                    end else begin
                        r_state       <= StFetch;
                        r_pc          <= (i_branch_en && i_cond_true) ? w_branch_pc
                                                                      : w_pc_plus_step;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                    end
                end
                StHalt: begin
                    r_state <= StHalt;
                end
                default: begin
                    r_state       <= StIdle;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus_step;
    assign o_imem_req    = r_imem_req;
    assign o_instr_valid = r_instr_valid;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic checked
// against a cycle-level reference of the fetch/execute rules.
module tb_pc_fetch_unit;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_HALT  = 3;

    logic        clk;
    logic        rst;
    logic        branch_en;
    logic        cond_true;
    logic [31:0] branch_target;
    logic        stall;
    logic        halt;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;

    int          checks;
    int          errors;

    // Reference model: what the sequencer is doing and which address it owns.
    int          m_mode;
    logic [31:0] m_pc;

    pc_fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_branch_en     (branch_en),
        .i_cond_true     (cond_true),
        .i_branch_target (branch_target),
        .i_stall         (stall),
        .i_halt          (halt),
        .i_imem_ready    (imem_ready),
        .o_imem_req      (imem_req),
        .o_pc            (pc),
        .o_pc_plus4      (pc_plus4),
        .o_instr_valid   (instr_valid),
        .o_halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        case (m_mode)
            M_IDLE:  m_mode = M_FETCH;
            M_FETCH: if (imem_ready) m_mode = M_EXEC;
            M_EXEC: begin
                if (stall) begin
                    m_mode = M_EXEC;
                end else if (halt) begin
                    m_mode = M_HALT;
                end else begin
                    if (branch_en && cond_true) m_pc = branch_target & ~32'd3;
                    else                        m_pc = m_pc + 32'd4;
                    m_mode = M_FETCH;
                end
            end
            default: m_mode = m_mode;
        endcase
    endtask

    // One clock: model consumes the inputs present at the edge, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Async reset pulse entirely between two rising edges.
    task automatic reset_pulse();
        #2 rst = 1'b1;
        m_mode = M_IDLE;
        m_pc   = 32'h0;
        #4 rst = 1'b0;
    endtask

    task automatic idle_inputs();
        branch_en = 1'b0; cond_true = 1'b0; branch_target = 32'h0;
        stall = 1'b0; halt = 1'b0; imem_ready = 1'b1;
    endtask

    task automatic run_to_exec();
        idle_inputs();
        for (int i = 0; i < 10 && m_mode != M_EXEC; i++) tick();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL run_to_exec: instr_valid got %b expected 1", instr_valid);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        m_mode = M_IDLE; m_pc = 32'h0;
        #13;
        checks++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: pc=%h req=%b valid=%b halted=%b expected 0/0/0/0",
                     pc, imem_req, instr_valid, halted);
        end
        checks++;
        if (pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_pc_plus4: got %h expected 00000004", pc_plus4);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        int          n_exec;
        logic [31:0] exp_pc;
        logic        prev_req;
        idle_inputs();
        n_exec   = 0;
        tick();
        prev_req = imem_req;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL seq_first_req: got %b expected 1", imem_req);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (imem_req !== ~prev_req || instr_valid !== prev_req) begin
                errors++;
                $display("FAIL seq_alternate: req=%b valid=%b expected req=%b valid=%b",
                         imem_req, instr_valid, ~prev_req, prev_req);
            end
            if (instr_valid === 1'b1) begin
                exp_pc = 32'(n_exec * 4);
                checks++;
                if (pc !== exp_pc) begin
                    errors++;
                    $display("FAIL seq_pc: got %h expected %h", pc, exp_pc);
                end
                n_exec++;
            end
            prev_req = imem_req;
        end
        checks++;
        if (n_exec != 4) begin
            errors++;
            $display("FAIL seq_exec_count: got %0d expected 4", n_exec);
        end
    endtask

    task automatic test_branch();
        run_to_exec();
        branch_en = 1'b1; cond_true = 1'b1; branch_target = 32'h0000_0103;
        tick();
        checks++;
        if (pc !== 32'h0000_0100 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL branch_taken: pc=%h req=%b expected 00000100/1", pc, imem_req);
        end
        run_to_exec();
        branch_en = 1'b1; cond_true = 1'b0; branch_target = 32'h0000_0800;
        tick();
        checks++;
        if (pc !== 32'h0000_0104) begin
            errors++;
            $display("FAIL branch_not_taken: pc=%h expected 00000104", pc);
        end
    endtask

    task automatic test_wait_states();
        int req_cycles;
        idle_inputs();
        imem_ready = 1'b0;
        req_cycles = (imem_req === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (imem_req === 1'b1) req_cycles++;
            checks++;
            if (pc !== 32'h0000_0104 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold: pc=%h valid=%b expected 00000104/0", pc, instr_valid);
            end
        end
        imem_ready = 1'b1;
        tick();
        checks++;
        if (req_cycles != 4 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL wait_release: req_cycles=%0d valid=%b req=%b expected 4/1/0",
                     req_cycles, instr_valid, imem_req);
        end
    endtask

    task automatic test_stall();
        int valid_cycles;
        valid_cycles = (instr_valid === 1'b1) ? 1 : 0;
        branch_en = 1'b1; cond_true = 1'b1; branch_target = 32'h0000_0200; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (instr_valid === 1'b1) valid_cycles++;
            checks++;
            if (pc !== 32'h0000_0104 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: pc=%h req=%b expected 00000104/0", pc, imem_req);
            end
        end
        halt = 1'b1;
        tick();
        checks++;
        if (halted !== 1'b0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_over_halt: halted=%b valid=%b expected 0/1", halted, instr_valid);
        end
        stall = 1'b0; halt = 1'b0;
        tick();
        checks++;
        if (valid_cycles != 3 || pc !== 32'h0000_0200 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: valid_cycles=%0d pc=%h req=%b expected 3/00000200/1",
                     valid_cycles, pc, imem_req);
        end
    endtask

    task automatic test_wrap_halt();
        run_to_exec();
        branch_en = 1'b1; cond_true = 1'b1; branch_target = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_setup: pc=%h pc_plus4=%h expected FFFFFFFC/00000000", pc, pc_plus4);
        end
        run_to_exec();
        tick();
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: got %h expected 00000000", pc);
        end
        run_to_exec();
        halt = 1'b1;
        tick();
        checks++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: halted=%b valid=%b req=%b expected 1/0/0",
                     halted, instr_valid, imem_req);
        end
        for (int i = 0; i < 6; i++) begin
            branch_en = 1'($urandom); cond_true = 1'b1; imem_ready = 1'($urandom);
            halt = 1'($urandom); branch_target = $urandom;
            tick();
            checks++;
            if (halted !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_sticky: halted=%b pc=%h req=%b valid=%b expected 1/0/0/0",
                         halted, pc, imem_req, instr_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        reset_pulse();
        idle_inputs();
        run_to_exec();
        tick();
        imem_ready = 1'b0;
        tick();
        #3 rst = 1'b1;
        #1;
        checks++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pc=%h req=%b halted=%b expected 00000000/0/0",
                     pc, imem_req, halted);
        end
        m_mode = M_IDLE; m_pc = 32'h0;
        #2 rst = 1'b0;
        imem_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_release_idle: req=%b expected 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || pc !== 32'h0) begin
            errors++;
            $display("FAIL async_refetch: req=%b pc=%h expected 1/00000000", imem_req, pc);
        end
    endtask

    task automatic test_random();
        int halt_cycles;
        halt_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            branch_en     = 1'($urandom);
            cond_true     = 1'($urandom);
            branch_target = $urandom;
            stall         = ($urandom_range(0, 3) == 0);
            halt          = ($urandom_range(0, 30) == 0);
            imem_ready    = ($urandom_range(0, 2) != 0);
            tick();
            checks++;
            if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || imem_req !== (m_mode == M_FETCH) ||
                instr_valid !== (m_mode == M_EXEC) || halted !== (m_mode == M_HALT)) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h p4=%h req=%b val=%b hlt=%b expected %h/%h/%b/%b/%b",
                         i, pc, pc_plus4, imem_req, instr_valid, halted, m_pc, m_pc + 32'd4,
                         m_mode == M_FETCH, m_mode == M_EXEC, m_mode == M_HALT);
            end
            if (m_mode == M_HALT) halt_cycles++;
            if (halt_cycles > 4) begin
                reset_pulse();
                halt_cycles = 0;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_wait_states();
        test_stall();
        test_wrap_halt();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
